player_motion: RTL and testbench
================================

Name: player_motion

Overview:
- Physics stage directly upstream of the VGA display controller.
- Once per frame it integrates accelerometer tilt and BTNU/BTNL/BTNR/BTND pushes into player velocity and position, clamps the position to the screen and detects player/target overlap.
- Outputs pixel-centre coordinates that drive the display's accel_x/accel_y inputs, plus a collision pulse and score for game logic.

Parameters:
- SCREEN_W, 640, visible width in pixels
- SCREEN_H, 480, visible height in pixels
- PLAYER_HALF, 25, player box half-size in pixels
- TARGET_HALF, 30, target box half-size in pixels
- FRAC_BITS, 4, fractional bits of velocity and position
- ACCEL_SHIFT, 4, arithmetic right shift applied to raw accel samples
- BTN_ACCEL, 8, Q.4 acceleration per held button per frame
- VMAX, 128, Q.4 velocity magnitude limit (8 px/frame)

Ports:
- clk_25mHz  in  1  pixel clock; single clock domain
- reset  in  1  asynchronous, active-low reset
- frame_tick  in  1  display screenEnd, high between frames
- accel_valid  in  1  one-cycle strobe: new accel sample
- accel_x_in  in  12  signed raw X tilt
- accel_y_in  in  12  signed raw Y tilt
- BTNU, BTND, BTNL, BTNR  in  1 each  synchronised push buttons
- target_x  in  32  target centre X in pixels (bits 9:0 used)
- target_y  in  32  target centre Y in pixels (bits 8:0 used)
- pos_x  out  32  player centre X, integer pixels, zero-extended
- pos_y  out  32  player centre Y, integer pixels, zero-extended
- update_done  out  1  one-cycle pulse when pos_x/pos_y are refreshed
- hit  out  1  one-cycle pulse on a new overlap
- score  out  8  hit count, saturating

Behaviour:
- Reset (async, reset=0):
  - pos_x=320, pos_y=240 (Q10.4 5120/3840); velocities 0.
  - Held samples 0, prev_overlap 0, hit 0, update_done 0, score 0, FSM IDLE.
- Sample hold: accel_valid=1 latches accel_x_in/accel_y_in into hold registers. The latest sample wins. Samples are never consumed or cleared.
- Frame trigger: rising edge of frame_tick, registered edge detect. While the FSM is not IDLE, edges are ignored.
- FSM, one state per cycle:
  - IDLE -> VEL -> FRIC -> POS -> CLAMP -> HIT -> IDLE.
  - update_done pulses in the HIT cycle: 6 cycles after the frame_tick rise.
- VEL: v' = v + (hold >>> ACCEL_SHIFT) + BTN_ACCEL*(BTNR-BTNL) for X, and (BTND-BTNU) for Y. Opposite buttons cancel. Use 18-bit signed intermediates.
- FRIC: v'' = v' - (v' >>> 3), then saturate to [-VMAX, +VMAX].
- POS: p' = p + v'' in 17-bit signed. p is unsigned Q10.4 X and Q9.4 Y.
- CLAMP (per axis, for X; Y uses SCREEN_H):
  - If p' < PLAYER_HALF<<FRAC_BITS: p = that minimum, v = 0.
  - If p' > (SCREEN_W-1-PLAYER_HALF)<<FRAC_BITS: p = that maximum, v = 0.
  - Otherwise p = p'.
  - Negative p' counts as below the minimum.
- Outputs: pos = p >> FRAC_BITS (truncate), registered in CLAMP. Values are stable between updates.
- HIT:
  - overlap = |pos_x - target_x| < PLAYER_HALF+TARGET_HALF AND the same test on Y. Absolute differences in 11-bit signed.
  - hit = overlap & ~prev_overlap. Then prev_overlap <= overlap.
  - On hit, score += 1, saturating at 255.
- Reset mid-update: the FSM aborts to IDLE with all state at reset values. No partial update is visible.
- accel_valid in the same cycle as VEL: VEL uses the old hold value; the new one applies next frame.

Decomposition:
- Package game_pkg holds:
  - SCREEN_W/SCREEN_H, PLAYER_HALF/TARGET_HALF, FRAC_BITS.
  - The state enum IDLE/VEL/FRIC/POS/CLAMP/HIT.
- Sub-module axis_integrator covers one axis: velocity, friction, saturation, position and clamp, with the axis limit as a parameter. It is instantiated twice, for X and Y.
- The top holds the sample hold, edge detect, FSM, overlap detection and score.

Test Plan:
- Reset -> pos_x=320, pos_y=240, score=0, hit=0. Asserting reset mid-FSM (the POS cycle) returns these values immediately.
- accel_x_in=256 held for 2 frames, targets far away -> after frame 1 v=14, pos_x=320. After frame 2 v=27, pos_x=322. update_done comes 6 cycles after each tick.
- accel_x_in=2047 for 2 frames -> v=112, then saturates to 128.
- BTNR and BTNL both held, accel 0 -> pos_x unchanged at 320.
- accel_x_in=-2048 for 60 frames -> pos_x settles at 25, v=0, never below 25. Same test with +2047 -> pos_x=614. Y axis -> 25 and 454.
- target at (360,240) from reset -> first update: hit pulses once, score=1. No further hit while overlapped. Target moved to (500,100) then back to (360,240) -> second hit, score=2.

Source files
------------

// File: rtl/game_pkg.sv
// Shared constants, FSM state type and a small arithmetic helper for the
// player_motion physics stage.
package game_pkg;

    localparam int SCREEN_W    = 640;   // visible width in pixels
    localparam int SCREEN_H    = 480;   // visible height in pixels
    localparam int PLAYER_HALF = 25;    // player box half-size in pixels
    localparam int TARGET_HALF = 30;    // target box half-size in pixels
    localparam int FRAC_BITS   = 4;     // fractional bits of velocity/position
    localparam int ACCEL_SHIFT = 4;     // arithmetic shift applied to raw tilt
    localparam int BTN_ACCEL   = 8;     // Q.4 acceleration per held button
    localparam int VMAX        = 128;   // Q.4 velocity magnitude limit

    // One state per pipeline step of the per-frame update.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        VEL   = 3'd1,
        FRIC  = 3'd2,
        POS   = 3'd3,
        CLAMP = 3'd4,
        HIT   = 3'd5
    } state_e;

    // Magnitude of an 11-bit signed coordinate difference.
    function automatic logic [10:0] abs11(input logic signed [10:0] d);
        logic [10:0] mag;
        if (d < 11'sd0) begin
            mag = 11'(-d);
        end else begin
            mag = 11'(d);
        end
        return mag;
    endfunction

endpackage

// File: rtl/player_motion_if.sv
// Signal bundle between the game/input side and the player_motion stage.
// slave  : the physics stage (consumes tilt/buttons/target, produces position).
// master : whoever drives frame timing and inputs and reads the results.
interface player_motion_if;
    logic               frame_tick;   // display screenEnd, high between frames
    logic               accel_valid;  // one-cycle strobe for a new tilt sample
    logic signed [11:0] accel_x_in;   // raw X tilt
    logic signed [11:0] accel_y_in;   // raw Y tilt
    logic               BTNU;
    logic               BTND;
    logic               BTNL;
    logic               BTNR;
    logic [31:0]        target_x;     // target centre X (bits 9:0 used)
    logic [31:0]        target_y;     // target centre Y (bits 8:0 used)
    logic [31:0]        pos_x;        // player centre X, integer pixels
    logic [31:0]        pos_y;        // player centre Y, integer pixels
    logic               update_done;  // pulse when pos_x/pos_y refresh
    logic               hit;          // pulse on a new overlap
    logic [7:0]         score;        // saturating hit count

    modport master (
        output frame_tick, accel_valid, accel_x_in, accel_y_in,
               BTNU, BTND, BTNL, BTNR, target_x, target_y,
        input  pos_x, pos_y, update_done, hit, score
    );

    modport slave (
        input  frame_tick, accel_valid, accel_x_in, accel_y_in,
               BTNU, BTND, BTNL, BTNR, target_x, target_y,
        output pos_x, pos_y, update_done, hit, score
    );
endinterface

// File: rtl/axis_integrator.sv
// One axis of player physics: velocity update, friction, saturation,
// position integration and screen clamp, stepped by the shared FSM state.
// Ports: clk/rst_n, state (current FSM step), accel (held raw tilt),
// btn_pos/btn_neg (buttons pushing towards +/- axis), pos_px (registered
// integer-pixel position, updated in CLAMP).
module axis_integrator
    import game_pkg::*;
#(
    parameter int LIMIT = SCREEN_W   // screen extent along this axis
) (
    input  logic               clk,
    input  logic               rst_n,
    input  state_e             state,
    input  logic signed [11:0] accel,
    input  logic               btn_pos,
    input  logic               btn_neg,
    output logic [9:0]         pos_px
);
    localparam logic signed [16:0] P_MIN = 17'(PLAYER_HALF << FRAC_BITS);
    localparam logic signed [16:0] P_MAX = 17'((LIMIT - 1 - PLAYER_HALF) << FRAC_BITS);
    localparam logic signed [16:0] P_RST = 17'((LIMIT / 2) << FRAC_BITS);
    localparam logic signed [17:0] V_LIM = 18'(VMAX);

    logic signed [17:0] vel_r;
    logic signed [16:0] pos_r;
    logic signed [16:0] pos_sum_r;     // unclamped p + v, held for CLAMP
    logic [9:0]         pos_px_r;
    logic signed [17:0] accel_ext_s;
    logic signed [17:0] accel_term_s;
    logic signed [17:0] btn_term_s;
    logic signed [17:0] fric_s;
    logic signed [17:0] fric_sat_s;
    logic signed [16:0] clamp_pos_s;
    logic               clamp_stop_s;

    // Tilt and button contributions to the velocity step.
    always_comb begin
        accel_ext_s  = {{6{accel[11]}}, accel};
        accel_term_s = accel_ext_s >>> ACCEL_SHIFT;
        case ({btn_pos, btn_neg})
            2'b10:   btn_term_s = 18'(BTN_ACCEL);
            2'b01:   btn_term_s = -18'(BTN_ACCEL);
            default: btn_term_s = 18'sd0;   // none or both: they cancel
        endcase
    end

    // Friction removes one eighth of the velocity, then the magnitude is limited.
    always_comb begin
        fric_s = vel_r - (vel_r >>> 3);
        if (fric_s > V_LIM) begin
            fric_sat_s = V_LIM;
        end else if (fric_s < -V_LIM) begin
            fric_sat_s = -V_LIM;
        end else begin
            fric_sat_s = fric_s;
        end
    end

    // Screen clamp; a negative sum is simply below the minimum.
    always_comb begin
        clamp_pos_s  = pos_sum_r;
        clamp_stop_s = 1'b0;
        if (pos_sum_r < P_MIN) begin
            clamp_pos_s  = P_MIN;
            clamp_stop_s = 1'b1;
        end else if (pos_sum_r > P_MAX) begin
            clamp_pos_s  = P_MAX;
            clamp_stop_s = 1'b1;
        end else begin
            clamp_pos_s  = pos_sum_r;
            clamp_stop_s = 1'b0;
        end
    end

    // Per-step state updates, one step per FSM state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vel_r     <= 18'sd0;
            pos_r     <= P_RST;
            pos_sum_r <= P_RST;
            pos_px_r  <= 10'(LIMIT / 2);
        end else begin
            case (state)
                VEL:   vel_r     <= vel_r + accel_term_s + btn_term_s;
                FRIC:  vel_r     <= fric_sat_s;
                POS:   pos_sum_r <= pos_r + 17'(vel_r);
                CLAMP: begin
                    pos_r    <= clamp_pos_s;
                    pos_px_r <= 10'(clamp_pos_s >>> FRAC_BITS);
                    if (clamp_stop_s) begin
                        vel_r <= 18'sd0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign pos_px = pos_px_r;
endmodule

// File: rtl/player_motion.sv
// Per-frame player physics: holds the latest tilt sample, detects the
// frame_tick rise, sequences the X/Y integrators, then checks player/target
// overlap and keeps a saturating score.
// Ports: clk_25mHz (pixel clock), reset (async active-low), bus (slave side
// of player_motion_if: tilt, buttons, target in; position, update_done,
// hit, score out).
// Timing: update_done pulses in the HIT cycle, 6 cycles after the tick rise;
// hit/score are evaluated in HIT and appear on the following cycle.
module player_motion
    import game_pkg::*;
(
    input  logic           clk_25mHz,
    input  logic           reset,
    player_motion_if.slave bus
);
    localparam logic [10:0] HIT_DIST = 11'(PLAYER_HALF + TARGET_HALF);

    logic signed [11:0] hold_x_r;
    logic signed [11:0] hold_y_r;
    logic               tick_prev_r;
    logic               rise_r;
    state_e             state_r;
    state_e             state_next_s;
    logic [9:0]         px_s;
    logic [9:0]         py_s;
    logic signed [10:0] dx_s;
    logic signed [10:0] dy_s;
    logic               overlap_s;
    logic               prev_overlap_r;
    logic               hit_r;
    logic               update_done_r;
    logic [7:0]         score_r;
    logic               unused_s;

    // Keep the newest tilt sample; it persists across frames.
    always_ff @(posedge clk_25mHz or negedge reset) begin
        if (!reset) begin
            hold_x_r <= 12'sd0;
            hold_y_r <= 12'sd0;
        end else if (bus.accel_valid) begin
            hold_x_r <= bus.accel_x_in;
            hold_y_r <= bus.accel_y_in;
        end
    end

    // Registered rising-edge detect of frame_tick.
    always_ff @(posedge clk_25mHz or negedge reset) begin
        if (!reset) begin
            tick_prev_r <= 1'b0;
            rise_r      <= 1'b0;
        end else begin
            tick_prev_r <= bus.frame_tick;
            rise_r      <= bus.frame_tick & ~tick_prev_r;
        end
    end

    // FSM state register.
    always_ff @(posedge clk_25mHz or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next state; a tick rise outside IDLE is dropped.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (rise_r) begin
                    state_next_s = VEL;
                end else begin
                    state_next_s = IDLE;
                end
            end
            VEL:     state_next_s = FRIC;
            FRIC:    state_next_s = POS;
            POS:     state_next_s = CLAMP;
            CLAMP:   state_next_s = HIT;
            HIT:     state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    axis_integrator #(.LIMIT(SCREEN_W)) u_x (
        .clk     (clk_25mHz),
        .rst_n   (reset),
        .state   (state_r),
        .accel   (hold_x_r),
        .btn_pos (bus.BTNR),
        .btn_neg (bus.BTNL),
        .pos_px  (px_s)
    );

    axis_integrator #(.LIMIT(SCREEN_H)) u_y (
        .clk     (clk_25mHz),
        .rst_n   (reset),
        .state   (state_r),
        .accel   (hold_y_r),
        .btn_pos (bus.BTND),
        .btn_neg (bus.BTNU),
        .pos_px  (py_s)
    );

    // Box overlap on both axes using the freshly clamped position.
    always_comb begin
        dx_s      = $signed({1'b0, px_s}) - $signed({1'b0, bus.target_x[9:0]});
        dy_s      = $signed({1'b0, py_s}) - $signed({2'b00, bus.target_y[8:0]});
        overlap_s = (abs11(dx_s) < HIT_DIST) && (abs11(dy_s) < HIT_DIST);
    end

    // Hit pulse, overlap history, score and update_done.
    always_ff @(posedge clk_25mHz or negedge reset) begin
        if (!reset) begin
            prev_overlap_r <= 1'b0;
            hit_r          <= 1'b0;
            score_r        <= 8'd0;
            update_done_r  <= 1'b0;
        end else begin
            update_done_r <= (state_r == CLAMP);
            if (state_r == HIT) begin
                hit_r          <= overlap_s & ~prev_overlap_r;
                prev_overlap_r <= overlap_s;
                if (overlap_s && !prev_overlap_r && (score_r != 8'd255)) begin
                    score_r <= score_r + 8'd1;
                end
            end else begin
                hit_r <= 1'b0;
            end
        end
    end

    assign unused_s        = ^{bus.target_x[31:10], bus.target_y[31:9]};
    assign bus.pos_x       = {22'd0, px_s};
    assign bus.pos_y       = {22'd0, py_s};
    assign bus.update_done = update_done_r;
    assign bus.hit         = hit_r;
    assign bus.score       = score_r;
endmodule

// File: tb/tb_player_motion.sv
// Self-checking bench for player_motion: directed frames from the test plan
// plus randomized frames, compared against a per-frame arithmetic model.
module tb_player_motion;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    player_motion_if bus();

    player_motion dut (
        .clk_25mHz (clk),
        .reset     (rst_n),
        .bus       (bus)
    );

    always #20 clk = ~clk;

    // Reference model state (Q.4 velocity/position as plain ints).
    int m_hx, m_hy, m_vx, m_vy, m_px, m_py, m_score;
    bit m_prev;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_hx = 0; m_hy = 0; m_vx = 0; m_vy = 0;
        m_px = 320 * 16; m_py = 240 * 16; m_score = 0; m_prev = 1'b0;
    endfunction

    function automatic void axis_step(input int hold, input int bp, input int bn,
                                      input int lim, inout int v, inout int p);
        v = v + (hold >>> 4) + 8 * (bp - bn);
        v = v - (v >>> 3);
        if (v > 128) v = 128;
        else if (v < -128) v = -128;
        p = p + v;
        if (p < 25 * 16) begin
            p = 25 * 16; v = 0;
        end else if (p > (lim - 1 - 25) * 16) begin
            p = (lim - 1 - 25) * 16; v = 0;
        end
    endfunction

    function automatic int iabs(input int a);
        return (a < 0) ? -a : a;
    endfunction

    task automatic check_reset_values(input string tag);
        check({tag, ".pos_x"}, int'(bus.pos_x), 320);
        check({tag, ".pos_y"}, int'(bus.pos_y), 240);
        check({tag, ".score"}, int'(bus.score), 0);
        check({tag, ".hit"}, int'(bus.hit), 0);
        check({tag, ".upd"}, int'(bus.update_done), 0);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        bus.frame_tick = 1'b0; bus.accel_valid = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_values(tag);
        rst_n = 1'b1;
        model_reset();
    endtask

    // One full frame: optional new sample, tick rise, wait for update_done,
    // compare position/velocity, then hit/score, then make sure nothing else fires.
    task automatic do_frame(input string tag, input int ax, input int ay, input bit av,
                            input bit u, input bit d, input bit l, input bit r,
                            input int tx, input int ty, input bit glitch);
        int  n;
        bit  got;
        int  extra;
        bit  ov;
        bit  exp_hit;
        @(negedge clk);
        bus.accel_valid = av;
        bus.accel_x_in = 12'(ax); bus.accel_y_in = 12'(ay);
        bus.BTNU = u; bus.BTND = d; bus.BTNL = l; bus.BTNR = r;
        bus.target_x = 32'(tx); bus.target_y = 32'(ty);
        @(negedge clk);
        bus.accel_valid = 1'b0;
        bus.frame_tick = 1'b1;
        n = 0; got = 1'b0;
        while (n < 20 && !got) begin
            @(negedge clk);
            n++;
            if (bus.update_done) got = 1'b1;
            if (n == 2) bus.frame_tick = 1'b0;
            if (n == 3 && glitch) bus.frame_tick = 1'b1;
            if (n == 4) bus.frame_tick = 1'b0;
        end
        bus.frame_tick = 1'b0;
        check({tag, ".latency"}, got ? n : -1, 6);

        if (av) begin m_hx = ax; m_hy = ay; end
        axis_step(m_hx, int'(r), int'(l), 640, m_vx, m_px);
        axis_step(m_hy, int'(d), int'(u), 480, m_vy, m_py);
        ov = (iabs((m_px >>> 4) - (tx & 1023)) < 55) &&
             (iabs((m_py >>> 4) - (ty & 511)) < 55);
        exp_hit = ov && !m_prev;
        if (exp_hit && m_score < 255) m_score++;
        m_prev = ov;

        check({tag, ".pos_x"}, int'(bus.pos_x), m_px >>> 4);
        check({tag, ".pos_y"}, int'(bus.pos_y), m_py >>> 4);
        check({tag, ".vel_x"}, int'(dut.u_x.vel_r), m_vx);
        check({tag, ".vel_y"}, int'(dut.u_y.vel_r), m_vy);
        @(negedge clk);
        check({tag, ".hit"}, int'(bus.hit), int'(exp_hit));
        check({tag, ".score"}, int'(bus.score), m_score);
        extra = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.update_done) extra++;
        end
        check({tag, ".extra_upd"}, extra, 0);
    endtask

    initial begin
        int cnt;
        rst_n = 1'b0;
        bus.frame_tick = 1'b0; bus.accel_valid = 1'b0;
        bus.accel_x_in = 12'sd0; bus.accel_y_in = 12'sd0;
        bus.BTNU = 1'b0; bus.BTND = 1'b0; bus.BTNL = 1'b0; bus.BTNR = 1'b0;
        bus.target_x = 32'd1000; bus.target_y = 32'd500;
        model_reset();

        // Tilt 256 for two frames: v 14 then 27, pos_x 320 then 322.
        do_reset("rst_a");
        do_frame("acc256_f1", 256, 0, 1'b1, 0, 0, 0, 0, 1000, 500, 1'b0);
        check("acc256_f1.spec_v", int'(dut.u_x.vel_r), 14);
        do_frame("acc256_f2", 256, 0, 1'b1, 0, 0, 0, 0, 1000, 500, 1'b1);
        check("acc256_f2.spec_pos", int'(bus.pos_x), 322);

        // Full tilt: 112 then saturates at 128.
        do_reset("rst_b");
        do_frame("acc2047_f1", 2047, 0, 1'b1, 0, 0, 0, 0, 1000, 500, 1'b0);
        do_frame("acc2047_f2", 2047, 0, 1'b0, 0, 0, 0, 0, 1000, 500, 1'b0);
        check("acc2047_f2.spec_v", int'(dut.u_x.vel_r), 128);

        // Opposite buttons cancel.
        do_reset("rst_c");
        for (int i = 0; i < 3; i++)
            do_frame($sformatf("btn_lr%0d", i), 0, 0, 1'b0, 1, 1, 1, 1, 1000, 500, 1'b0);
        check("btn_lr.spec_pos", int'(bus.pos_x), 320);

        // Clamp at the low corner, sample sent only once.
        do_reset("rst_d");
        for (int i = 0; i < 60; i++)
            do_frame($sformatf("neg%0d", i), -2048, -2048, i == 0, 0, 0, 0, 0, 1000, 500, i[0]);
        check("neg.spec_x", int'(bus.pos_x), 25);
        check("neg.spec_y", int'(bus.pos_y), 25);

        // Clamp at the high corner.
        do_reset("rst_e");
        for (int i = 0; i < 60; i++)
            do_frame($sformatf("pos%0d", i), 2047, 2047, 1'b1, 0, 0, 0, 0, 1000, 500, 1'b0);
        check("pos.spec_x", int'(bus.pos_x), 614);
        check("pos.spec_y", int'(bus.pos_y), 454);

        // Hit on new overlap only.
        do_reset("rst_f");
        do_frame("hit1", 0, 0, 1'b0, 0, 0, 0, 0, 360, 240, 1'b0);
        do_frame("hit_hold", 0, 0, 1'b0, 0, 0, 0, 0, 360, 240, 1'b0);
        do_frame("hit_away", 0, 0, 1'b0, 0, 0, 0, 0, 500, 100, 1'b0);
        do_frame("hit2", 0, 0, 1'b0, 0, 0, 0, 0, 360, 240, 1'b0);
        check("hit2.spec_score", int'(bus.score), 2);

        // Reset during the POS step: reset values appear immediately.
        do_frame("pre_mid0", 2047, -2048, 1'b1, 0, 0, 0, 0, 1000, 500, 1'b0);
        @(negedge clk);
        bus.frame_tick = 1'b1;
        @(negedge clk);
        bus.frame_tick = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_values("mid_rst");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.update_done) cnt++;
        end
        check("mid_rst.no_upd", cnt, 0);
        do_frame("post_mid", 0, 0, 1'b0, 0, 0, 0, 0, 1000, 500, 1'b0);

        // Randomized frames with targets near the player.
        do_reset("rst_r");
        for (int i = 0; i < 80; i++) begin
            int ax, ay, tx, ty;
            ax = int'($urandom_range(0, 4095)) - 2048;
            ay = int'($urandom_range(0, 4095)) - 2048;
            tx = (m_px >>> 4) + int'($urandom_range(0, 140)) - 70;
            ty = (m_py >>> 4) + int'($urandom_range(0, 140)) - 70;
            do_frame($sformatf("rnd%0d", i), ax, ay, 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     tx, ty, 1'($urandom_range(0, 1)));
        end

        // Score saturation: alternate overlapping and distant targets.
        do_reset("rst_s");
        for (int i = 0; i < 258; i++) begin
            do_frame($sformatf("sat_on%0d", i), 0, 0, 1'b0, 0, 0, 0, 0, 320, 240, 1'b0);
            do_frame($sformatf("sat_off%0d", i), 0, 0, 1'b0, 0, 0, 0, 0, 1000, 500, 1'b0);
        end
        check("sat.spec_score", int'(bus.score), 255);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
